// File: rtl/phase_gen.sv
`timescale 1ns/1ps
// phase_gen: parametrised multi-phase machine-cycle generator.
// Divides clk_in into machine cycles of PHASES phases, each div+1 clk_in
// cycles long. Supports free-run (mode=0, gated by en) and single-step
// (mode=1, one cycle per step request) operation. Cycles always complete.
//
// Ports:
//   clk_in     - system clock
//   rst        - asynchronous active-high reset
//   en         - run enable (free-run mode)
//   mode       - 0 = free-run, 1 = single-step
//   step       - single-step request, level-sampled in IDLE
//   div        - phase length minus one, latched at phase-0 entry
//   out        - phase clock, high in even-indexed phases
//   acc_write  - WR_MASK[phase_idx] while active
//   phase      - one-hot current phase, zero when idle
//   phase_idx  - binary current phase, zero when idle
//   cycle_done - high for the final clk_in cycle of the last phase
//   busy       - high while running or stepping
module phase_gen #(
    parameter int                PHASES  = 4,
    parameter int                DIV_W   = 8,
    parameter logic [PHASES-1:0] WR_MASK = PHASES'(4'b0110),
    localparam int               PW      = (PHASES > 2) ? $clog2(PHASES) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              step,
    input  logic [DIV_W-1:0]  div,
    output logic              out,
    output logic              acc_write,
    output logic [PHASES-1:0] phase,
    output logic [PW-1:0]     phase_idx,
    output logic              cycle_done,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

    logic [1:0]       state, state_n;
    logic [PW-1:0]    idx, idx_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_q, div_q_n;
    logic             active_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        div_q_n = div_q;
        case (state)
            S_IDLE: begin
                idx_n = '0;
                cnt_n = '0;
                if (!mode && en) begin
                    state_n = S_RUN;
                    div_q_n = div;
                end else if (mode && step) begin
                    state_n = S_STEP;
                    div_q_n = div;
                end
            end
            S_RUN, S_STEP: begin
                if (cnt == div_q) begin
                    cnt_n = '0;
                    if (idx == LAST) begin
                        // Cycle boundary: only here are en/mode consulted again.
                        idx_n = '0;
                        if (state == S_RUN && !mode && en)
                            div_q_n = div;
                        else
                            state_n = S_IDLE;
                    end else begin
                        idx_n = idx + PW'(1);
                    end
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    assign active_n = (state_n != S_IDLE);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            div_q <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            div_q <= div_q_n;
        end
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe without any combinational path from inputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            out        <= 1'b0;
            acc_write  <= 1'b0;
            phase      <= '0;
            phase_idx  <= '0;
            cycle_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out        <= active_n & ~idx_n[0];
            acc_write  <= active_n & WR_MASK[idx_n];
            phase      <= active_n ? (PHASES'(1) << idx_n) : '0;
            phase_idx  <= idx_n;
            cycle_done <= active_n && (idx_n == LAST) && (cnt_n == div_q_n);
            busy       <= active_n;
        end
    end

endmodule

// File: tb/tb_phase_gen.sv
`timescale 1ns/1ps
module tb_phase_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       step = 1'b0;
    logic [7:0] div = '0;

    logic       o4, a4, cd4, b4;
    logic [3:0] ph4;
    logic [1:0] pi4;
    logic       o3, a3, cd3, b3;
    logic [2:0] ph3;
    logic [1:0] pi3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_gen #(.PHASES(4), .DIV_W(8), .WR_MASK(4'b0110)) dut4 (
        .clk_in(clk), .rst(rst), .en(en), .mode(mode), .step(step), .div(div),
        .out(o4), .acc_write(a4), .phase(ph4), .phase_idx(pi4),
        .cycle_done(cd4), .busy(b4)
    );

    phase_gen #(.PHASES(3), .DIV_W(8), .WR_MASK(3'b100)) dut3 (
        .clk_in(clk), .rst(rst), .en(en), .mode(mode), .step(step), .div(div),
        .out(o3), .acc_write(a3), .phase(ph3), .phase_idx(pi3),
        .cycle_done(cd3), .busy(b3)
    );

    // Reference: a machine cycle is a position t in 0..P*(d+1)-1.
    typedef struct {
        bit act;
        bit run;
        int t;
        int d;
    } ms_t;

    ms_t m4, m3;

    function automatic ms_t mnext(ms_t s, int p, bit r, bit md, bit e, bit st, int dv);
        ms_t n;
        n = s;
        if (r) begin
            n = '{0, 0, 0, 0};
        end else if (!s.act) begin
            if (!md && e)      n = '{1, 1, 0, dv};
            else if (md && st) n = '{1, 0, 0, dv};
        end else if (s.t == p * (s.d + 1) - 1) begin
            if (s.run && !md && e) begin
                n.t = 0;
                n.d = dv;
            end else begin
                n = '{0, 0, 0, s.d};
            end
        end else begin
            n.t = s.t + 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag, input ms_t s, input int p, input int mask,
                               input int a_out, input int a_acc, input int a_ph,
                               input int a_idx, input int a_done, input int a_busy);
        int pi;
        pi = s.act ? s.t / (s.d + 1) : 0;
        chk({tag, "_out"},   a_out,  s.act ? int'(pi % 2 == 0) : 0);
        chk({tag, "_acc"},   a_acc,  s.act ? ((mask >> pi) & 1) : 0);
        chk({tag, "_phase"}, a_ph,   s.act ? (1 << pi) : 0);
        chk({tag, "_idx"},   a_idx,  pi);
        chk({tag, "_done"},  a_done, int'(s.act && s.t == p * (s.d + 1) - 1));
        chk({tag, "_busy"},  a_busy, int'(s.act));
    endtask

    task automatic check_both(input string tag);
        check_model({tag, "_p4"}, m4, 4, 6, o4, a4, ph4, pi4, cd4, b4);
        check_model({tag, "_p3"}, m3, 3, 4, o3, a3, ph3, pi3, cd3, b3);
    endtask

    // One clk_in edge: advance the model on the inputs present at the edge,
    // then compare just after it.
    task automatic tick(input string tag);
        m4 = mnext(m4, 4, rst, mode, en, step, int'(div));
        m3 = mnext(m3, 3, rst, mode, en, step, int'(div));
        @(posedge clk);
        #1;
        check_both(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; step = 1'b0;
        tick("rst");
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] dv;
        logic       e_out;
        logic       e_acc;
        logic       e_done;
        int         e_idx;
    } vec_t;

    vec_t vt[8];

    initial begin
        m4 = '{0, 0, 0, 0};
        m3 = '{0, 0, 0, 0};

        // Legacy four-phase pattern, two back-to-back cycles.
        vt[0] = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 0};
        vt[1] = '{1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1};
        vt[2] = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 2};
        vt[3] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 3};
        vt[4] = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 0};
        vt[5] = '{1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1};
        vt[6] = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 2};
        vt[7] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 3};

        #3;
        check_both("por");
        do_reset();

        for (int i = 0; i < 8; i++) begin
            en = vt[i].en;
            div = vt[i].dv;
            tick("legacy");
            chk("legacy_out",  o4,  vt[i].e_out);
            chk("legacy_acc",  a4,  vt[i].e_acc);
            chk("legacy_done", cd4, vt[i].e_done);
            chk("legacy_idx",  pi4, vt[i].e_idx);
        end

        // Divider 2, then div=0 during phase 1 of the second cycle.
        do_reset();
        en = 1'b1; div = 8'd2;
        for (int i = 1; i <= 28; i++) begin
            tick("divider");
            chk("div_done4", cd4, int'(i == 12 || i == 24 || i == 28));
            if (i == 16) div = 8'd0;
        end

        // Halt at boundary: en dropped in phase 1 with div=1.
        do_reset();
        en = 1'b1; div = 8'd1;
        for (int i = 1; i <= 12; i++) begin
            tick("halt");
            chk("halt_busy", b4, int'(i <= 8));
            chk("halt_done", cd4, int'(i == 8));
            if (i >= 9) chk("halt_out", o4, 0);
            if (i == 3) en = 1'b0;
        end

        // Single step: held through the cycle, then re-requested after IDLE.
        do_reset();
        mode = 1'b1; div = 8'd0; step = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick("step");
            chk("step_busy", b4, int'(i <= 4 || i == 7));
            chk("step_done", cd4, int'(i == 4));
            if (i == 4) step = 1'b0;
            if (i == 6) step = 1'b1;
        end
        step = 1'b0;
        for (int i = 0; i < 5; i++) tick("step_tail");

        // Reset asserted mid-cycle in phase 2 with div=3.
        do_reset();
        mode = 1'b0; en = 1'b1; div = 8'd3;
        for (int i = 1; i <= 10; i++) tick("rstmid");
        chk("rstmid_pre_idx", pi4, 2);
        #2;
        rst = 1'b1;
        #1;
        m4 = '{0, 0, 0, 0};
        m3 = '{0, 0, 0, 0};
        chk("rstmid_busy",  b4,  0);
        chk("rstmid_phase", ph4, 0);
        chk("rstmid_out",   o4,  0);
        chk("rstmid_idx",   pi4, 0);
        check_both("rstmid_async");
        #1;
        rst = 1'b0;
        tick("rstmid_restart");
        chk("rstmid_restart_phase", ph4, 1);
        chk("rstmid_restart_busy",  b4,  1);

        // Randomised stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = ($urandom_range(0, 3) == 0);
            step = $urandom_range(0, 1);
            div  = 8'($urandom_range(0, 3));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
